// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache for the CPU fetch port with a single-outstanding
// refill engine; drives a NOP (zero) whenever the fetched word is not yet available.
module inst_fetch_cache #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        instReady,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic [31:0] memData,
    input  logic        memReady,
    output logic [31:0] missCount
);
    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = 30 - OFF - IDX;
    localparam int LA  = 30 - OFF;

    typedef enum logic {IDLE, REFILL} stateT;

    stateT            stateReg, stateNext;
    logic [OFF-1:0]   cntReg, cntNext;
    logic [LA-1:0]    lineReg, lineNext;
    logic [31:0]      missReg, missNext;
    logic [LINES-1:0] validReg, validNext;
    logic             dataWe, tagWe;

    logic [31:0]      dataArr [LINES*LINE_WORDS];
    logic [TAG-1:0]   tagArr  [LINES];

    logic [OFF-1:0]   pcOff;
    logic [IDX-1:0]   pcIdx;
    logic [TAG-1:0]   pcTag;
    logic [IDX-1:0]   lineIdx;
    logic [TAG-1:0]   lineTag;
    logic             hit;
    logic             lastWord;
    logic             unusedPcBits;

    assign pcOff        = pc[2 +: OFF];
    assign pcIdx        = pc[2+OFF +: IDX];
    assign pcTag        = pc[31 -: TAG];
    assign unusedPcBits = ^pc[1:0];
    // lineReg holds the line address (pc[31:2+OFF]); its low bits are the index.
    assign lineIdx      = lineReg[IDX-1:0];
    assign lineTag      = lineReg[LA-1:IDX];
    assign lastWord     = (cntReg == OFF'(LINE_WORDS - 1));

    assign hit       = (stateReg == IDLE) && validReg[pcIdx] && (tagArr[pcIdx] == pcTag);
    assign instReady = hit;
    assign inst      = hit ? dataArr[{pcIdx, pcOff}] : 32'h0;
    assign memReq    = (stateReg == REFILL);
    assign memAddr   = memReq ? {lineReg, cntReg, 2'b00} : 32'h0;
    assign missCount = missReg;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        lineNext  = lineReg;
        missNext  = missReg;
        validNext = validReg;
        dataWe    = 1'b0;
        tagWe     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (!hit) begin
                    // Invalidate up front so an interrupted refill never leaves a stale hit.
                    lineNext         = pc[31:2+OFF];
                    cntNext          = '0;
                    missNext         = missReg + 32'd1;
                    validNext[pcIdx] = 1'b0;
                    stateNext        = REFILL;
                end
            end
            REFILL: begin
                if (memReady) begin
                    dataWe = 1'b1;
                    if (lastWord) begin
                        tagWe              = 1'b1;
                        validNext[lineIdx] = 1'b1;
                        stateNext          = IDLE;
                    end else begin
                        cntNext = cntReg + OFF'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            lineReg  <= '0;
            missReg  <= 32'h0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            lineReg  <= lineNext;
            missReg  <= missNext;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : gValid
            always_ff @(posedge clk or posedge reset) begin
                if (reset) validReg[gi] <= 1'b0;
                else       validReg[gi] <= validNext[gi];
            end
        end
    endgenerate

    // Data and tag storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (dataWe) dataArr[{lineIdx, cntReg}] <= memData;
        if (tagWe)  tagArr[lineIdx]            <= lineTag;
    end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Bench for inst_fetch_cache: backing memory returns addr ^ 0xA5A50000 after a
// programmable latency; an address-level cache model checks every cycle.
module tb_inst_fetch_cache;
    localparam int LINES = 16;
    localparam int LW    = 4;
    localparam logic [31:0] K = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        instReady;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        memReady;
    logic [31:0] missCount;

    always #5 clk = ~clk;

    inst_fetch_cache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst), .instReady(instReady),
        .memReq(memReq), .memAddr(memAddr), .memData(memData), .memReady(memReady),
        .missCount(missCount)
    );

    int checks = 0;
    int errors = 0;

    // backing memory responder
    int lat = 3;
    int reqCycles = 0;
    bit spurious = 0;

    // address-level reference model
    bit          mValid [LINES];
    logic [31:0] mBase  [LINES];
    bit          mActive;
    logic [31:0] mRefBase;
    int          mDone;
    logic [31:0] mMiss;

    // values sampled in the most recent cycle
    logic        sReady, sMemReady, sMemReq;
    logic [31:0] sInst, sMemAddr, sMiss;
    logic [31:0] capAddrs[$];

    typedef struct {
        logic [31:0] pc;
        int          lat;
        int          pen;
        logic [31:0] inst;
        int          miss;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mActive = 0;
        mDone   = 0;
        mMiss   = 32'h0;
        foreach (mValid[i]) mValid[i] = 0;
    endtask

    task automatic modelStep();
        logic [31:0] base;
        int          idx;
        int          ridx;
        bit          hit;
        base = pc & ~32'(LW*4 - 1);
        idx  = int'((pc / (LW*4)) % LINES);
        if (reset) begin
            chk("rst instReady", 32'(instReady), 32'h0);
            chk("rst inst", inst, 32'h0);
            chk("rst memReq", 32'(memReq), 32'h0);
            chk("rst memAddr", memAddr, 32'h0);
            chk("rst missCount", missCount, 32'h0);
            modelReset();
            return;
        end
        if (!mActive) begin
            hit = mValid[idx] && (mBase[idx] == base);
            chk("instReady", 32'(instReady), 32'(hit));
            chk("inst", inst, hit ? ({pc[31:2], 2'b00} ^ K) : 32'h0);
            chk("memReq idle", 32'(memReq), 32'h0);
            chk("memAddr idle", memAddr, 32'h0);
            chk("missCount", missCount, mMiss);
            if (!hit) begin
                mActive     = 1;
                mRefBase    = base;
                mDone       = 0;
                mMiss       = mMiss + 32'd1;
                mValid[idx] = 0;
            end
        end else begin
            chk("instReady refill", 32'(instReady), 32'h0);
            chk("inst refill", inst, 32'h0);
            chk("memReq refill", 32'(memReq), 32'h1);
            chk("memAddr refill", memAddr, mRefBase + 32'(4*mDone));
            chk("missCount refill", missCount, mMiss);
            if (memReady) begin
                mDone++;
                if (mDone == LW) begin
                    ridx         = int'((mRefBase / (LW*4)) % LINES);
                    mActive      = 0;
                    mValid[ridx] = 1;
                    mBase[ridx]  = mRefBase;
                end
            end
        end
    endtask

    // Called just after a rising edge: drive this cycle's memory response, check, advance.
    task automatic cycle();
        if (!reset && memReq) begin
            reqCycles++;
            if (reqCycles >= lat) begin
                memReady  = 1'b1;
                reqCycles = 0;
            end else begin
                memReady = 1'b0;
            end
        end else begin
            reqCycles = 0;
            memReady  = spurious;
        end
        memData  = memReady ? (memReq ? (memAddr ^ K) : 32'hDEADBEEF) : 32'h0;
        spurious = 0;
        #1;
        sReady    = instReady;
        sInst     = inst;
        sMemReq   = memReq;
        sMemAddr  = memAddr;
        sMemReady = memReady;
        sMiss     = missCount;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] p, input int l, output int penalty);
        bit done;
        pc      = p;
        lat     = l;
        penalty = 0;
        done    = 0;
        capAddrs.delete();
        for (int n = 0; n < 200; n++) begin
            cycle();
            if (sReady) begin
                done = 1;
                break;
            end
            penalty++;
            if (sMemReady && sMemReq) capAddrs.push_back(sMemAddr);
        end
        chk("fetch completes", 32'(done), 32'h1);
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] bases [3];
        bases[0] = 32'h00400000;
        bases[1] = 32'h00400100;
        bases[2] = 32'h10000000;
        return bases[$urandom_range(2)] + 32'($urandom_range(3) * LW * 4)
             + 32'($urandom_range(LW-1) * 4) + 32'($urandom_range(3));
    endfunction

    initial begin
        int pen;
        int rdyCount;
        int lastRdy;
        int n;
        logic [31:0] base;

        vecs[0] = '{32'h00400000, 3, 13, 32'hA5E50000, 1};
        vecs[1] = '{32'h00400004, 3,  0, 32'hA5E50004, 1};
        vecs[2] = '{32'h00400008, 3,  0, 32'hA5E50008, 1};
        vecs[3] = '{32'h0040000C, 3,  0, 32'hA5E5000C, 1};
        vecs[4] = '{32'h00400100, 3, 13, 32'hA5E50100, 2};
        vecs[5] = '{32'h00400000, 3, 13, 32'hA5E50000, 3};
        vecs[6] = '{32'h00400080, 1,  5, 32'hA5E50080, 4};
        vecs[7] = '{32'h0040008E, 1,  0, 32'hA5E5008C, 4};

        reset    = 1'b1;
        pc       = 32'h00400000;
        memReady = 1'b0;
        memData  = 32'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 1'b0;

        // Table: cold fetch, line hits, conflict eviction, back-to-back refill.
        for (int v = 0; v < 8; v++) begin
            fetch(vecs[v].pc, vecs[v].lat, pen);
            chk($sformatf("vec%0d penalty", v), 32'(pen), 32'(vecs[v].pen));
            chk($sformatf("vec%0d inst", v), sInst, vecs[v].inst);
            chk($sformatf("vec%0d missCount", v), sMiss, 32'(vecs[v].miss));
            if (vecs[v].pen > 0) begin
                base = vecs[v].pc & ~32'(LW*4 - 1);
                chk($sformatf("vec%0d refill words", v), 32'(capAddrs.size()), 32'(LW));
                for (int i = 0; i < capAddrs.size(); i++)
                    chk($sformatf("vec%0d memAddr%0d", v, i), capAddrs[i], base + 32'(4*i));
            end
            $display("vec %0d pc=%h penalty=%0d inst=%h miss=%0d", v, vecs[v].pc, pen, sInst, sMiss);
        end

        // Redirect to a cached pc after the 2nd word; the refill must still complete.
        pc = 32'h00400040;
        lat = 3;
        rdyCount = 0;
        lastRdy = -1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (sReady) break;
            if (sMemReady) begin
                rdyCount++;
                lastRdy = n;
                if (rdyCount == 2) pc = 32'h00400000;
            end
            n++;
        end
        chk("redirect words", 32'(rdyCount), 32'h4);
        chk("redirect hit cycle", 32'(n), 32'(lastRdy + 1));
        chk("redirect inst", sInst, 32'hA5E50000);
        chk("redirect ready", 32'(sReady), 32'h1);
        fetch(32'h00400044, 3, pen);
        chk("redirected line installed", 32'(pen), 32'h0);
        $display("redirect: words=%0d hit_cycle=%0d inst=%h miss=%0d", rdyCount, n, sInst, sMiss);

        // Asynchronous reset between the 2nd and 3rd word of a refill.
        pc = 32'h004000C0;
        lat = 3;
        rdyCount = 0;
        for (int c = 0; c < 100 && rdyCount < 2; c++) begin
            cycle();
            if (sMemReady) rdyCount++;
        end
        chk("pre-reset words", 32'(rdyCount), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("async memReq", 32'(memReq), 32'h0);
        chk("async instReady", 32'(instReady), 32'h0);
        chk("async missCount", missCount, 32'h0);
        chk("async memAddr", memAddr, 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        spurious = 1;
        fetch(32'h004000C0, 2, pen);
        chk("post-reset penalty", 32'(pen), 32'd9);
        chk("post-reset inst", sInst, 32'h004000C0 ^ K);
        chk("post-reset missCount", sMiss, 32'h1);
        chk("post-reset words", 32'(capAddrs.size()), 32'(LW));
        if (capAddrs.size() > 0) chk("post-reset restart addr", capAddrs[0], 32'h004000C0);
        $display("reset mid-refill: penalty=%0d inst=%h miss=%0d", pen, sInst, sMiss);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 30) pc = randPc();
            if ($urandom_range(99) < 10) lat = 1 + int'($urandom_range(2));
            if (!memReq && $urandom_range(99) < 5) spurious = 1;
            reset = ($urandom_range(299) == 0);
            cycle();
        end
        reset = 1'b0;
        $display("random: %0d cycles, missCount=%0d", 1500, sMiss);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
